// File: rtl/gpu_pkg.sv
// Shared scheduler definitions: FSM state encoding, the 3-bit external state
// code and the mapping from FSM state to the stage strobes.
package gpu_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_SELECT  = 4'd1,
    S_FETCH   = 4'd2,
    S_DECODE  = 4'd3,
    S_REQUEST = 4'd4,
    S_WAIT    = 4'd5,
    S_EXECUTE = 4'd6,
    S_UPDATE  = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  typedef struct packed {
    logic fetch;
    logic decode;
    logic request;
    logic execute;
    logic update;
    logic done;
  } strobes_t;

  localparam logic [2:0] CODE_IDLE    = 3'd0;
  localparam logic [2:0] CODE_FETCH   = 3'd1;
  localparam logic [2:0] CODE_DECODE  = 3'd2;
  localparam logic [2:0] CODE_REQUEST = 3'd3;
  localparam logic [2:0] CODE_WAIT    = 3'd4;
  localparam logic [2:0] CODE_EXECUTE = 3'd5;
  localparam logic [2:0] CODE_UPDATE  = 3'd6;
  localparam logic [2:0] CODE_DONE    = 3'd7;

  // Nine states do not fit three bits: SELECT is reported as part of the
  // fetch phase, since it is the single scheduling cycle that precedes FETCH.
  function automatic logic [2:0] state_code(input state_t s);
    case (s)
      S_IDLE:    state_code = CODE_IDLE;
      S_SELECT:  state_code = CODE_FETCH;
      S_FETCH:   state_code = CODE_FETCH;
      S_DECODE:  state_code = CODE_DECODE;
      S_REQUEST: state_code = CODE_REQUEST;
      S_WAIT:    state_code = CODE_WAIT;
      S_EXECUTE: state_code = CODE_EXECUTE;
      S_UPDATE:  state_code = CODE_UPDATE;
      S_DONE:    state_code = CODE_DONE;
      default:   state_code = CODE_IDLE;
    endcase
  endfunction

  function automatic strobes_t state_strobes(input state_t s);
    state_strobes         = '0;
    state_strobes.fetch   = (s == S_FETCH);
    state_strobes.decode  = (s == S_DECODE);
    state_strobes.request = (s == S_REQUEST);
    state_strobes.execute = (s == S_EXECUTE);
    state_strobes.update  = (s == S_UPDATE);
    state_strobes.done    = (s == S_DONE);
  endfunction

endpackage

// File: rtl/warp_rr_arbiter.sv
// Round-robin warp picker: first requesting warp strictly after ptr, wrapping.
module warp_rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] grant,
  output logic            any_valid
);

  int idx;

  // Scan ptr+1 .. ptr+N (mod N); ptr itself is considered last.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any_valid && req[idx]) begin
        any_valid = 1'b1;
        grant     = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/core_scheduler.sv
// Per-core warp scheduler: round-robin warp issue through a fixed
// fetch/decode/request/wait/execute/update instruction sequence.
module core_scheduler
  import gpu_pkg::*;
#(
  parameter int MAX_WARPS_PER_CORE = 4,
  parameter int THREADS_PER_WARP   = 4,
  parameter int PC_BITS            = 8,
  parameter int WID_W = (MAX_WARPS_PER_CORE > 1) ? $clog2(MAX_WARPS_PER_CORE) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [7:0]                  thread_count,
  output logic                        fetch_enable,
  output logic [PC_BITS-1:0]          fetch_pc,
  input  logic                        instruction_ready,
  input  logic                        decoded_done,
  input  logic                        decoded_mem_access,
  input  logic [THREADS_PER_WARP-1:0] lsu_busy,
  input  logic [PC_BITS-1:0]          next_pc,
  output logic [WID_W-1:0]            current_warp_id,
  output logic [THREADS_PER_WARP-1:0] thread_mask,
  output logic [2:0]                  core_state,
  output logic                        decode_enable,
  output logic                        request_enable,
  output logic                        execute_enable,
  output logic                        update_enable,
  output logic                        done
);

  localparam int NW  = MAX_WARPS_PER_CORE;
  localparam int TPW = THREADS_PER_WARP;

  state_t             state, next_state;
  strobes_t           stb;
  logic [WID_W-1:0]   cur, grant, scan_ptr;
  logic               any_valid;
  logic               fresh;
  logic [NW-1:0]      warp_done, done_after_update;
  logic [7:0]         tc_reg;
  logic [TPW-1:0]     mask_q;
  logic [PC_BITS-1:0] pcs [NW];

  // Warps beyond ceil(tc/TPW) (saturated at NW) start out retired.
  function automatic logic [NW-1:0] launch_done_mask(input logic [7:0] tc);
    int wc;
    wc = (int'(tc) + TPW - 1) / TPW;
    if (wc > NW) wc = NW;
    for (int i = 0; i < NW; i++) launch_done_mask[i] = (i >= wc);
  endfunction

  // Lane l of warp id is valid when its global thread index is below tc.
  function automatic logic [TPW-1:0] lane_mask(input logic [7:0] tc, input logic [WID_W-1:0] id);
    int rem;
    rem = int'(tc) - int'(id) * TPW;
    for (int l = 0; l < TPW; l++) lane_mask[l] = (l < rem);
  endfunction

  // Right after launch the scan must begin at warp 0, i.e. "after" warp NW-1.
  assign scan_ptr = fresh ? WID_W'(NW - 1) : cur;

  warp_rr_arbiter #(.N(NW), .ID_W(WID_W)) u_arb (
    .req       (~warp_done),
    .ptr       (scan_ptr),
    .grant     (grant),
    .any_valid (any_valid)
  );

  // Retirement vector as it will look once the current UPDATE commits.
  always_comb begin
    done_after_update = warp_done;
    if (decoded_done) done_after_update[cur] = 1'b1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (start) next_state = (thread_count == 8'd0) ? S_DONE : S_SELECT;
      S_SELECT:  next_state = any_valid ? S_FETCH : S_DONE;
      S_FETCH:   if (instruction_ready) next_state = S_DECODE;
      S_DECODE:  next_state = S_REQUEST;
      S_REQUEST: next_state = S_WAIT;
      S_WAIT:    if (!decoded_mem_access || ((lsu_busy & mask_q) == '0)) next_state = S_EXECUTE;
      S_EXECUTE: next_state = S_UPDATE;
      S_UPDATE:  next_state = (&done_after_update) ? S_DONE : S_SELECT;
      S_DONE:    next_state = S_DONE;
      default:   next_state = S_IDLE;
    endcase
  end

  // Output decode: strobes follow the current state only.
  always_comb begin
    stb = state_strobes(state);
  end

  // Warp context: launch setup, selection and PC / retirement commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur       <= '0;
      mask_q    <= '0;
      warp_done <= '0;
      tc_reg    <= '0;
      fresh     <= 1'b0;
      for (int i = 0; i < NW; i++) pcs[i] <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          tc_reg    <= thread_count;
          warp_done <= launch_done_mask(thread_count);
          fresh     <= 1'b1;
        end
        S_SELECT: if (any_valid) begin
          cur    <= grant;
          mask_q <= lane_mask(tc_reg, grant);
          fresh  <= 1'b0;
        end
        S_UPDATE: begin
          if (decoded_done) warp_done[cur] <= 1'b1;
          else              pcs[cur]       <= next_pc;
        end
        default: ;
      endcase
    end
  end

  assign fetch_enable    = stb.fetch;
  assign decode_enable   = stb.decode;
  assign request_enable  = stb.request;
  assign execute_enable  = stb.execute;
  assign update_enable   = stb.update;
  assign done            = stb.done;
  assign fetch_pc        = pcs[cur];
  assign current_warp_id = cur;
  assign thread_mask     = mask_q;
  assign core_state      = state_code(state);

endmodule
